ts_channel_selector: RTL

- Channel-selection engine for the 4-input MPEG-2 TS QoS controller.
- Sits between the per-channel TS monitors, which supply presence levels and error pulses, and the register block, which supplies configuration and reads back status.
- Maintains windowed per-channel error counters, decides channel health, and selects the active output channel by manual override or by priority/fallback policy.
- Outputs feed the TS output mux and the status register inputs (active_channel, signal_present, error_count_ch0..3).

---
 rtl/ts_qos_pkg.sv | 23 ++
 rtl/ts_err_window_counter.sv | 56 +++++
 rtl/ts_channel_selector.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ts_qos_pkg.sv
// Shared definitions for the 4-input TS QoS controller: channel sizing,
// selection-state encoding and the power-on channel priority order.
package ts_qos_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W-1:0] ch_t;

  typedef enum logic [1:0] {
    S_AUTO   = 2'd0,
    S_MANUAL = 2'd1,
    S_NONE   = 2'd2
  } sel_state_e;

  localparam logic [7:0] PRIO_RESET_DEFAULT = 8'b11100100;

  // Entry idx of the packed priority list; entry 0 is the highest rank.
  function automatic ch_t prio_entry(input logic [7:0] prio, input int idx);
    return prio[idx*CH_W +: CH_W];
  endfunction

endpackage

// File: rtl/ts_err_window_counter.sv
// Window timer plus one saturating error counter per channel. All counters
// clear when the window expires; expire_o is the registered expire pulse.
module ts_err_window_counter
  import ts_qos_pkg::*;
#(
  parameter int TIMER_W = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           err_pulse,
  input  logic [TIMER_W-1:0]          reset_timer,
  output logic [NUM_CH-1:0][7:0]      count_o,
  output logic                        expire_o
);

  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [NUM_CH-1:0][7:0] count_q, count_d;
  logic                   expire_s;
  logic                   expire_q;

  // ">=" rather than "==" so a shortened window still expires promptly.
  always_comb begin
    expire_s = (reset_timer != '0) && (timer_q >= (reset_timer - TIMER_W'(1)));
    if (expire_s || (reset_timer == '0)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
    count_d = count_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (expire_s) begin
        count_d[n] = err_pulse[n] ? 8'd1 : 8'd0;
      end else if (err_pulse[n] && (count_q[n] != 8'hFF)) begin
        count_d[n] = count_q[n] + 8'd1;
      end else begin
        count_d[n] = count_q[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= '0;
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      count_q  <= count_d;
      expire_q <= expire_s;
    end
  end

  assign count_o  = count_q;
  assign expire_o = expire_q;

endmodule

// File: rtl/ts_channel_selector.sv
// Channel-selection engine: tracks channel health from windowed error counts
// and picks the active TS channel by manual override or priority/fallback.
module ts_channel_selector
  import ts_qos_pkg::*;
#(
  parameter int ERR_THRESH = 8,
  parameter int TIMER_W    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         err_pulse,
  input  logic [3:0]         signal_in,
  input  logic               fallback_enable,
  input  logic               manual_enable,
  input  logic [1:0]         manual_channel,
  input  logic [7:0]         channel_priority,
  input  logic [TIMER_W-1:0] reset_timer,
  output logic [1:0]         active_channel,
  output logic [3:0]         signal_present,
  output logic [7:0]         error_count_ch0,
  output logic [7:0]         error_count_ch1,
  output logic [7:0]         error_count_ch2,
  output logic [7:0]         error_count_ch3,
  output logic               switch_event,
  output logic               no_valid_channel
);

  localparam logic [7:0] THRESH_C = 8'(ERR_THRESH);

  sel_state_e             state_q, state_d;
  ch_t                    active_q, active_d;
  logic [NUM_CH-1:0]      sig_q;
  logic                   sw_q, sw_d;
  logic                   nvc_q, nvc_d;
  logic [NUM_CH-1:0][7:0] cnt_s;
  logic                   expire_s;
  logic [NUM_CH-1:0]      healthy_s;
  logic                   cand_valid_s;
  ch_t                    cand_s;
  logic                   cur_listed_s;

  ts_err_window_counter #(.TIMER_W(TIMER_W)) u_err_window (
    .clk         (clk),
    .rst         (rst),
    .err_pulse   (err_pulse),
    .reset_timer (reset_timer),
    .count_o     (cnt_s),
    .expire_o    (expire_s)
  );

  // First healthy listed channel wins; duplicates keep their first rank.
  always_comb begin
    healthy_s    = '0;
    cand_valid_s = 1'b0;
    cand_s       = '0;
    cur_listed_s = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      healthy_s[n] = sig_q[n] && (cnt_s[n] < THRESH_C);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!cand_valid_s && healthy_s[prio_entry(channel_priority, k)]) begin
        cand_valid_s = 1'b1;
        cand_s       = prio_entry(channel_priority, k);
      end else begin
        cand_valid_s = cand_valid_s;
      end
      if (prio_entry(channel_priority, k) == active_q) begin
        cur_listed_s = 1'b1;
      end else begin
        cur_listed_s = cur_listed_s;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    if (manual_enable) begin
      state_d  = S_MANUAL;
      active_d = manual_channel;
    end else begin
      case (state_q)
        S_MANUAL: begin
          state_d = S_AUTO;
          if (!fallback_enable) begin
            active_d = prio_entry(channel_priority, 0);
          end else if (cand_valid_s) begin
            active_d = cand_s;
          end else begin
            state_d = S_NONE;
          end
        end
        S_AUTO: begin
          if (!fallback_enable) begin
            active_d = prio_entry(channel_priority, 0);
          end else if (!healthy_s[active_q] || !cur_listed_s) begin
            if (cand_valid_s) begin
              active_d = cand_s;
            end else begin
              state_d = S_NONE;
            end
          end else if (expire_s && cand_valid_s) begin
            // Current channel is healthy, so any other candidate outranks it.
            active_d = cand_s;
          end else begin
            active_d = active_q;
          end
        end
        S_NONE: begin
          if (!fallback_enable) begin
            state_d = S_AUTO;
          end else if (cand_valid_s) begin
            state_d  = S_AUTO;
            active_d = cand_s;
          end else begin
            state_d = S_NONE;
          end
        end
        default: begin
          state_d = S_AUTO;
        end
      endcase
    end
    nvc_d = (state_d == S_NONE);
    sw_d  = (active_d != active_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_AUTO;
      active_q <= '0;
      sig_q    <= '0;
      sw_q     <= 1'b0;
      nvc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      sig_q    <= signal_in;
      sw_q     <= sw_d;
      nvc_q    <= nvc_d;
    end
  end

  assign active_channel   = active_q;
  assign signal_present   = sig_q;
  assign switch_event     = sw_q;
  assign no_valid_channel = nvc_q;
  assign error_count_ch0  = cnt_s[0];
  assign error_count_ch1  = cnt_s[1];
  assign error_count_ch2  = cnt_s[2];
  assign error_count_ch3  = cnt_s[3];

endmodule
